// File: rtl/fixed_sv_div.sv
`default_nettype none
// ============================================================================
// fixed_sv_div : iterative Q-format vector / scalar divider (3 lanes, shared
//                restoring-division control, saturating signed results)
// Revision 1.0
// ============================================================================
module fixed_sv_div #(
  parameter int TOTAL_PREC = 27,
  parameter int FRAC_BITS  = 22
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [TOTAL_PREC-1:0] a [2:0],
  input  logic signed [TOTAL_PREC-1:0] b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [TOTAL_PREC-1:0] res [2:0],
  output logic                         div_zero
);

  localparam int P  = TOTAL_PREC;
  localparam int N  = TOTAL_PREC + FRAC_BITS;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [N-1:0] MAX_Q   = {{(N-P+1){1'b0}}, {(P-1){1'b1}}};
  localparam logic [N-1:0] MIN_MAG = {{(N-P){1'b0}}, 1'b1, {(P-1){1'b0}}};
  localparam logic [P-1:0] RES_MAX = {1'b0, {(P-1){1'b1}}};
  localparam logic [P-1:0] RES_MIN = {1'b1, {(P-1){1'b0}}};

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [P-1:0]  divisor;
  logic          b_zero;
  logic [P-1:0]  b_u;
  logic [P-1:0]  b_mag;
  logic [P-1:0]  fix_res [3];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Unsigned magnitude so that |-2^(P-1)| stays exact.
  assign b_u   = b;
  assign b_mag = b_u[P-1] ? -b_u : b_u;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [P-1:0] a_u;
      logic [P-1:0] a_mag;
      logic [P-1:0] rem;
      logic [N-1:0] dvd;
      logic         neg;
      logic         a_zero;
      logic [P:0]   trial;
      logic         take;
      logic [P-1:0] nrem;
      logic [P-1:0] fix_val;

      always_comb begin
        a_u   = a[gi];
        a_mag = a_u[P-1] ? -a_u : a_u;
        trial = {rem, dvd[N-1]};
        take  = (trial >= {1'b0, divisor});
        nrem  = trial[P-1:0] - (take ? divisor : '0);
      end

      // dvd doubles as the quotient register: quotient bits shift in at the LSB.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem    <= '0;
          dvd    <= '0;
          neg    <= 1'b0;
          a_zero <= 1'b0;
        end else if (state == IDLE && in_valid) begin
          rem    <= '0;
          dvd    <= {a_mag, {FRAC_BITS{1'b0}}};
          neg    <= a_u[P-1] ^ b_u[P-1];
          a_zero <= (a_u == '0);
        end else if (state == DIV) begin
          rem    <= nrem;
          dvd    <= {dvd[N-2:0], take};
        end
      end

      always_comb begin
        if (a_zero)
          fix_val = '0;
        else if (b_zero)
          fix_val = neg ? RES_MIN : RES_MAX;
        else if (!neg)
          fix_val = (dvd > MAX_Q) ? RES_MAX : dvd[P-1:0];
        else
          fix_val = (dvd > MIN_MAG) ? RES_MIN : -dvd[P-1:0];
      end

      assign fix_res[gi] = fix_val;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      divisor  <= '0;
      b_zero   <= 1'b0;
      div_zero <= 1'b0;
      for (int k = 0; k < 3; k++) res[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            divisor <= b_mag;
            b_zero  <= (b_u == '0);
            cnt     <= '0;
            state   <= DIV;
          end
        end
        DIV: begin
          if (cnt == CW'(N - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          for (int k = 0; k < 3; k++) res[k] <= fix_res[k];
          div_zero <= b_zero;
          state    <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fixed_sv_div.sv
`default_nettype none
// ============================================================================
// tb_fixed_sv_div : scoreboard bench for fixed_sv_div against an arithmetic
//                   reference model (directed cases plus random traffic)
// Revision 1.0
// ============================================================================
module tb_fixed_sv_div;

  localparam int P   = 27;
  localparam int F   = 22;
  localparam int N   = P + F;
  localparam int LAT = N + 1;
  localparam longint MAXV = (longint'(1) <<< (P - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (P - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, div_zero;
  logic signed [P-1:0] a [2:0];
  logic signed [P-1:0] b;
  logic signed [P-1:0] res [2:0];

  typedef struct {
    longint r0;
    longint r1;
    longint r2;
    logic   dz;
    int     acc;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   rand_rdy = 0;
  logic prev_ov = 1'b0;

  fixed_sv_div #(.TOTAL_PREC(P), .FRAC_BITS(F)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: exact rational quotient truncated toward zero, then clamped.
  function automatic longint model(input logic signed [P-1:0] x, input logic signed [P-1:0] y);
    longint q;
    if (x == 0) return 0;
    if (y == 0) return (x > 0) ? MAXV : MINV;
    q = (longint'(x) * (longint'(1) <<< F)) / longint'(y);
    if (q > MAXV) q = MAXV;
    if (q < MINV) q = MINV;
    return q;
  endfunction

  function automatic logic signed [P-1:0] rnd_val();
    logic signed [P-1:0] v;
    v = $signed(P'($urandom));
    return v >>> $urandom_range(0, P - 1);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        me = sb.pop_front();
        chk("res0", res[0], me.r0);
        chk("res1", res[1], me.r1);
        chk("res2", res[2], me.r2);
        chk("div_zero", div_zero, me.dz);
        chk("latency", cyc - me.acc, LAT);
      end
    end
    prev_ov = out_valid;
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic signed [P-1:0] x0, input logic signed [P-1:0] x1,
                      input logic signed [P-1:0] x2, input logic signed [P-1:0] y);
    exp_t e;
    int   t = 0;
    while (!in_ready && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) timeout("accept_wait");
    a[0] = x0; a[1] = x1; a[2] = x2; b = y;
    in_valid = 1'b1;
    e.r0  = model(x0, y);
    e.r1  = model(x1, y);
    e.r2  = model(x2, y);
    e.dz  = (y == 0);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a[0] = rnd_val(); a[1] = rnd_val(); a[2] = rnd_val(); b = rnd_val();
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 400) timeout("idle_wait");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint e0, e1, e2;
    int     t;
    for (int k = 0; k < 3; k++) a[k] = '0;
    b = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res0", res[0], 0);
    chk("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(8388608, -6291456, 2097152, 2097152);        wait_idle();
    send(4194304, -4194304, 1, 12582912);             wait_idle();
    send(33554432, -33554432, -67108864, 1048576);    wait_idle();
    send(4194304, -4194304, 0, 0);                    wait_idle();
    send(-67108864, 67108863, -1, -67108864);         wait_idle();
    send(-67108864, 1, -5, -1);                       wait_idle();

    // Backpressure: result held, new requests ignored until the handshake.
    out_ready = 1'b0;
    send(4194304, -12582912, 6291456, -8388608);
    e0 = model(4194304, -8388608);
    e1 = model(-12582912, -8388608);
    e2 = model(6291456, -8388608);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!out_valid) timeout("bp_out_valid");
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0);
      a[0] = rnd_val(); b = rnd_val();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_res0", res[0], e0);
      chk("bp_res1", res[1], e1);
      chk("bp_res2", res[2], e2);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    wait_idle();

    // Reset in the middle of a division.
    send(33554432, -4194304, 12345, 3);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_res0", res[0], 0);
    chk("abort_res1", res[1], 0);
    chk("abort_res2", res[2], 0);
    chk("abort_div_zero", div_zero, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4194304, 0, 0, 4194304);
    wait_idle();

    // Random traffic with random output stalls.
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      send(rnd_val(), rnd_val(), rnd_val(),
           ($urandom_range(0, 9) == 0) ? '0 : rnd_val());
    end
    rand_rdy = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
